set_bit_serializer: RTL and testbench

//   Serializes a vector into its set bits, one per beat: one-hot mask plus binary index, in priority order.

---
 rtl/set_bit_serializer.sv | 106 ++++++++++
 tb/tb_set_bit_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_serializer.sv
// Serializes a vector into its set bits, one beat per accepted cycle: one-hot mask,
// binary index and last flag, in priority order (highest or lowest set bit first).
module set_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic             last_o,
    output logic             data_val_o,
    input  logic             ready_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] onehot_nxt;
    logic [IDX_W-1:0] index_nxt;
    logic             last_nxt;
    logic             val_nxt;
    logic             out_free;

    // The output register can take a new beat when empty or being drained this cycle.
    assign out_free = !data_val_o || ready_i;
    assign busy_o   = (state == ST_RUN) || !out_free;
    assign src      = (state == ST_IDLE) ? data_i : rem;

    // Priority pick: later loop iterations override earlier ones.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (src[i]) begin
                    pick_oh    = '0;
                    pick_oh[i] = 1'b1;
                    pick_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (src[i]) begin
                    pick_oh    = '0;
                    pick_oh[i] = 1'b1;
                    pick_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Next-state and next-beat logic; everything holds while the output is stalled.
    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        val_nxt    = data_val_o;
        onehot_nxt = onehot_o;
        index_nxt  = index_o;
        last_nxt   = last_o;
        if (out_free) begin
            val_nxt    = 1'b0;
            onehot_nxt = '0;
            index_nxt  = '0;
            last_nxt   = 1'b0;
            if ((state == ST_RUN) || data_val_i) begin
                rem_nxt    = src & ~pick_oh;
                val_nxt    = 1'b1;
                onehot_nxt = pick_oh;
                index_nxt  = pick_idx;
                last_nxt   = (rem_nxt == '0);
                state_nxt  = (rem_nxt == '0) ? ST_IDLE : ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= ST_IDLE;
            rem        <= '0;
            data_val_o <= 1'b0;
            onehot_o   <= '0;
            index_o    <= '0;
            last_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            rem        <= rem_nxt;
            data_val_o <= val_nxt;
            onehot_o   <= onehot_nxt;
            index_o    <= index_nxt;
            last_o     <= last_nxt;
        end
    end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed bench for set_bit_serializer: a scoreboard of expected beats for the MSB-first
// instance, plus direct checks on an LSB-first instance for the reset-abort sequence.
module tb_set_bit_serializer;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       data_val_i = 1'b0;
    logic       ready_i = 1'b1;

    logic       busy_o, last_o, data_val_o;
    logic [7:0] onehot_o;
    logic [2:0] index_o;
    logic       busy_l, last_l, val_l;
    logic [7:0] onehot_l;
    logic [2:0] index_l;

    int    checks = 0;
    int    failures = 0;
    int    pops = 0;
    bit    mon_en = 1'b1;
    beat_t q[$];

    always #5 clk = ~clk;

    set_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(data_i), .data_val_i(data_val_i),
        .busy_o(busy_o), .onehot_o(onehot_o), .index_o(index_o), .last_o(last_o),
        .data_val_o(data_val_o), .ready_i(ready_i)
    );

    set_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(data_i), .data_val_i(data_val_i),
        .busy_o(busy_l), .onehot_o(onehot_l), .index_o(index_l), .last_o(last_l),
        .data_val_o(val_l), .ready_i(ready_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected MSB-first beats of a vector.
    task automatic push_vec(input logic [7:0] v);
        beat_t b;
        int    n;
        int    k;
        n = $countones(v);
        k = 0;
        if (n == 0) begin
            b = '{oh: 8'h00, idx: 3'd0, last: 1'b1};
            q.push_back(b);
        end else begin
            for (int j = 7; j >= 0; j--) begin
                if (v[j]) begin
                    k++;
                    b.oh    = 8'h00;
                    b.oh[j] = 1'b1;
                    b.idx   = 3'(j);
                    b.last  = (k == n);
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic monitor();
        beat_t e;
        if (mon_en && data_val_o) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = q[0];
                check("beat_onehot", 32'(onehot_o), 32'(e.oh));
                check("beat_index", 32'(index_o), 32'(e.idx));
                check("beat_last", 32'(last_o), 32'(e.last));
                if (ready_i) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
    endtask

    // One cycle: checks at negedge (-1 = don't care), then advance to just after posedge.
    task automatic tick(input int exp_busy, input int exp_val);
        @(negedge clk);
        if (exp_busy >= 0) check("busy", 32'(busy_o), 32'(exp_busy));
        if (exp_val >= 0) check("data_val_o", 32'(data_val_o), 32'(exp_val));
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drained(input string tag, input int exp_pops);
        check({tag, "_beats"}, 32'(pops), 32'(exp_pops));
        check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
        check({tag, "_idle_val"}, 32'(data_val_o), 32'd0);
        pops = 0;
    endtask

    initial begin
        #2 arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val", 32'(data_val_o), 32'd0);
        check("rst_onehot", 32'(onehot_o), 32'd0);
        check("rst_index", 32'(index_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: two set bits, ready always high
        data_i = 8'b0100_1000; data_val_i = 1'b1; push_vec(data_i);
        tick(0, 0);
        data_val_i = 1'b0;
        tick(1, 1);
        tick(0, 1);
        tick(0, 0);
        drained("t1", 2);

        // 2: a vector offered while busy is dropped
        data_i = 8'b0100_1000; data_val_i = 1'b1; push_vec(data_i);
        tick(0, 0);
        data_i = 8'hFF;
        tick(1, 1);
        data_val_i = 1'b0;
        tick(0, 1);
        tick(0, 0);
        tick(0, 0);
        drained("t2", 2);

        // 3: zero vector gives one empty last beat
        data_i = 8'h00; data_val_i = 1'b1; push_vec(data_i);
        tick(0, 0);
        data_val_i = 1'b0;
        tick(0, 1);
        tick(0, 0);
        drained("t3", 1);

        // 4: all ones with ready stalls; monitor re-checks the held beat each cycle
        data_i = 8'hFF; data_val_i = 1'b1; push_vec(data_i);
        tick(0, 0);
        data_val_i = 1'b0;
        for (int i = 0; i < 24; i++) begin
            ready_i = (i % 3 == 0);
            tick((i < 19) ? 1 : -1, (i < 22) ? 1 : 0);
        end
        ready_i = 1'b1;
        tick(0, 0);
        drained("t4", 8);

        // 5: back-to-back vectors, no bubble between them
        data_i = 8'b0010_0010; data_val_i = 1'b1; push_vec(data_i); push_vec(8'h81);
        tick(0, 0);
        data_i = 8'h81;
        tick(1, 1);
        tick(0, 1);
        data_val_i = 1'b0;
        tick(1, 1);
        tick(0, 1);
        tick(0, 0);
        drained("t5", 4);

        // 6: LSB-first instance, reset mid-vector
        mon_en = 1'b0;
        data_i = 8'hA0; data_val_i = 1'b1;
        tick(0, 0);
        data_val_i = 1'b0;
        @(negedge clk);
        check("lsb_first_val", 32'(val_l), 32'd1);
        check("lsb_first_onehot", 32'(onehot_l), 32'h20);
        check("lsb_first_index", 32'(index_l), 32'd5);
        check("lsb_first_last", 32'(last_l), 32'd0);
        check("lsb_first_busy", 32'(busy_l), 32'd1);
        arst_n = 1'b0;
        #1;
        check("lsb_rst_val", 32'(val_l), 32'd0);
        check("lsb_rst_onehot", 32'(onehot_l), 32'd0);
        check("lsb_rst_index", 32'(index_l), 32'd0);
        check("lsb_rst_last", 32'(last_l), 32'd0);
        check("lsb_rst_busy", 32'(busy_l), 32'd0);
        check("msb_rst_val", 32'(data_val_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        pops = 0;
        mon_en = 1'b1;
        data_i = 8'h06; data_val_i = 1'b1; push_vec(data_i);
        tick(0, 0);
        data_val_i = 1'b0;
        @(negedge clk);
        check("lsb_post_val", 32'(val_l), 32'd1);
        check("lsb_post_index", 32'(index_l), 32'd1);
        check("lsb_post_last", 32'(last_l), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lsb_post2_index", 32'(index_l), 32'd2);
        check("lsb_post2_last", 32'(last_l), 32'd1);
        @(posedge clk);
        #1;
        tick(0, 0);
        check("lsb_post_idle", 32'(val_l), 32'd0);
        check("msb_post_queue", 32'(q.size()), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
